rc4_pt_check: RTL and testbench
===============================

Name: rc4_pt_check

Overview:
Reader/checker for the decrypted-message memory that the RC4 decrypt block writes.
- On a valid/ready request it reads the length-prefixed message (dm[0] = length L, dm[1..L] = plaintext).
- It checks that every plaintext byte is printable ASCII and reports pass/fail plus the index of the first offending byte.
- It sits beside the decrypt block on the shared read port of the decrypted memory. The future key-search controller uses it after each decrypt attempt.

Parameters:
- CH_LO, 8'h20, lowest acceptable character (inclusive).
- CH_HI, 8'h7E, highest acceptable character (inclusive).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- valid  input  1  request to start a check
- ready  output  1  high when idle and able to accept a request
- dm_addr  output  8  read address into decrypted memory
- dm_rddata  input  8  read data; synchronous RAM, data for the address presented in cycle N appears in cycle N+1
- ok  output  1  result: 1 = all L bytes in [CH_LO, CH_HI]
- bad_idx  output  8  index (1..255) of first failing byte; 0 when ok=1
- done  output  1  one-cycle pulse when a result is published

Behaviour:
- Reset (async): state IDLE, ready=1, ok=0, bad_idx=0, done=0, dm_addr=0, internal len/idx=0.
- Handshake:
  - A start is accepted on a rising edge where valid&&ready. ready drops the following cycle.
  - valid is ignored while ready=0.
  - ready returns high in the same cycle that done pulses.
  - ok and bad_idx are registered and held until the next result.
  - They are cleared to 0 on acceptance of a new start.
- States:
  - IDLE: dm_addr=0, ready=1. On accept go to LEN.
  - LEN: dm_addr=0. Next state LWAIT.
  - LWAIT: dm_addr=1 (prefetch). dm_rddata = dm[0]; latch as len.
    - If dm[0]==0: ok=1, bad_idx=0, done=1, go to IDLE.
    - Otherwise idx=1, go to SCAN.
  - SCAN: dm_addr=idx+1 (pipelined, one byte per cycle). dm_rddata = dm[idx].
    - If byte < CH_LO or > CH_HI: ok=0, bad_idx=idx, done=1, go to IDLE (early abort; the in-flight prefetch is discarded).
    - Else if idx==len: ok=1, bad_idx=0, done=1, go to IDLE.
    - Else idx<=idx+1.
- Latency:
  - All-pass with length L≥1: ready low for exactly L+3 cycles.
  - L=0: ready low for 3 cycles.
  - First bad byte at k: ready low for k+3 cycles.
- Boundaries:
  - Comparisons are unsigned 8-bit, inclusive at both ends (0x20 and 0x7E pass; 0x1F and 0x7F fail).
  - L=255: the prefetch address idx+1 wraps to 0 in the final cycle. That read is harmless and ignored.
  - dm_addr is driven only in LEN/LWAIT/SCAN per above; it returns to 0 in IDLE.
  - The block never writes memory.
  - Reset mid-operation returns to IDLE immediately with all reset values. No done pulse.
  - valid held high continuously: a new check starts on the first cycle ready=1. The result of the previous check is still visible for that one cycle (the done cycle).

Decomposition:
- Shared package rc4_pkg holds:
  - state enum {IDLE, LEN, LWAIT, SCAN};
  - constants CH_LO_DEF=8'h20 and CH_HI_DEF=8'h7E;
  - a function is_printable(byte, lo, hi).
- Single module; no sub-module is warranted.
- The bench reuses the existing s_mem-style synchronous RAM model as the decrypted memory.

Test Plan:
- Memory "05 48 65 6C 6C 6F" ("Hello"), pulse valid -> ready low 8 cycles, done pulse, ok=1, bad_idx=0; dm_addr sequence 0,1,2,3,4,5,6.
- dm[0]=00 -> ready low 3 cycles, ok=1, bad_idx=0, only address 0 consumed.
- "04 41 42 0A 43" -> abort at index 3: ok=0, bad_idx=3, ready low 6 cycles, dm[4] never checked.
- Boundary bytes "04 20 7E 1F 7F" -> ok=0, bad_idx=3; same check with "02 20 7E" -> ok=1.
- Length 255, all 0x61 -> ok=1 after 258 low cycles; wrap of dm_addr to 0 on the last cycle has no effect.
- Assert rst_n low mid-SCAN of the "Hello" case -> ready=1, ok=0, bad_idx=0, dm_addr=0, no done. A following request completes normally. valid pulsed while busy -> ignored.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 plaintext checker and its neighbours.
package rc4_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEN   = 2'd1,
        LWAIT = 2'd2,
        SCAN  = 2'd3
    } state_t;

    localparam logic [7:0] CH_LO_DEF = 8'h20;
    localparam logic [7:0] CH_HI_DEF = 8'h7E;

    function automatic logic is_printable(input logic [7:0] ch,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
        return (ch >= lo) && (ch <= hi);
    endfunction

endpackage

// File: rtl/rc4_pt_check.sv
// Reads a length-prefixed message from the decrypted memory and reports whether
// every plaintext byte is printable, plus the index of the first offending byte.
//
// state | meaning
// IDLE  | ready for a request; publishes a pending result for one cycle
// LEN   | address 0 presented to the RAM
// LWAIT | dm[0] arrives and becomes len; byte 1 prefetched
// SCAN  | dm[idx] checked each cycle while dm[idx+1] is prefetched
module rc4_pt_check
    import rc4_pkg::*;
#(
    parameter logic [7:0] CH_LO = CH_LO_DEF,
    parameter logic [7:0] CH_HI = CH_HI_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid,
    output logic       ready,
    output logic [7:0] dm_addr,
    input  logic [7:0] dm_rddata,
    output logic       ok,
    output logic [7:0] bad_idx,
    output logic       done
);

    state_t     state;
    logic [7:0] len;
    logic [7:0] idx;
    logic       pend;
    logic       res_ok;
    logic [7:0] res_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready   <= 1'b1;
            ok      <= 1'b0;
            bad_idx <= 8'd0;
            done    <= 1'b0;
            dm_addr <= 8'd0;
            len     <= 8'd0;
            idx     <= 8'd0;
            pend    <= 1'b0;
            res_ok  <= 1'b0;
            res_bad <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    dm_addr <= 8'd0;
                    // A decided result is published one cycle after the decision,
                    // together with ready, so done and ready rise in the same cycle.
                    if (pend) begin
                        pend    <= 1'b0;
                        ready   <= 1'b1;
                        done    <= 1'b1;
                        ok      <= res_ok;
                        bad_idx <= res_bad;
                    end else if (valid && ready) begin
                        ready   <= 1'b0;
                        ok      <= 1'b0;
                        bad_idx <= 8'd0;
                        state   <= LEN;
                    end
                end
                LEN: begin
                    dm_addr <= 8'd1;
                    state   <= LWAIT;
                end
                LWAIT: begin
                    len <= dm_rddata;
                    if (dm_rddata == 8'd0) begin
                        res_ok  <= 1'b1;
                        res_bad <= 8'd0;
                        pend    <= 1'b1;
                        dm_addr <= 8'd0;
                        state   <= IDLE;
                    end else begin
                        idx     <= 8'd1;
                        dm_addr <= 8'd2;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (!is_printable(dm_rddata, CH_LO, CH_HI)) begin
                        res_ok  <= 1'b0;
                        res_bad <= idx;
                        pend    <= 1'b1;
                        dm_addr <= 8'd0;
                        state   <= IDLE;
                    end else if (idx == len) begin
                        res_ok  <= 1'b1;
                        res_bad <= 8'd0;
                        pend    <= 1'b1;
                        dm_addr <= 8'd0;
                        state   <= IDLE;
                    end else begin
                        // Wraps to 0 for the last byte of a 255-byte message; that read is unused.
                        idx     <= idx + 8'd1;
                        dm_addr <= idx + 8'd2;
                    end
                end
                default: begin
                    state   <= IDLE;
                    dm_addr <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_pt_check.sv
// Directed and randomized checks of rc4_pt_check against a message-level reference
// model, with a synchronous RAM standing in for the decrypted memory.
module tb_rc4_pt_check;

    logic       clk;
    logic       rst_n;
    logic       valid;
    logic       ready;
    logic [7:0] dm_addr;
    logic [7:0] dm_rddata;
    logic       ok;
    logic [7:0] bad_idx;
    logic       done;

    logic [7:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    int e_ok;
    int e_bad;
    int e_lat;
    int exp_addr[$];
    int got_addr[$];

    rc4_pt_check dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (valid),
        .ready     (ready),
        .dm_addr   (dm_addr),
        .dm_rddata (dm_rddata),
        .ok        (ok),
        .bad_idx   (bad_idx),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) dm_rddata <= mem[dm_addr];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    // Reference: walk the message as a string, find the first byte outside
    // [0x20,0x7E], and list the addresses the reader is expected to present.
    task automatic model();
        int l;
        int n;
        l     = mem[0];
        e_ok  = 1;
        e_bad = 0;
        for (int i = 1; i <= l; i++) begin
            if (mem[i] < 8'h20 || mem[i] > 8'h7E) begin
                e_ok  = 0;
                e_bad = i;
                break;
            end
        end
        n = e_ok ? l : e_bad;
        exp_addr.delete();
        exp_addr.push_back(0);
        exp_addr.push_back(1);
        for (int i = 1; i <= n; i++) exp_addr.push_back((i + 1) % 256);
        exp_addr.push_back(0);
        e_lat = n + 3;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Entered at the negedge of the first busy cycle; returns at the negedge of the done cycle.
    task automatic monitor(input string tag, input bit poke);
        int cyc;
        int dones;
        int addr_err;
        model();
        chk({tag, " ok cleared"}, ok, 0);
        chk({tag, " bad_idx cleared"}, bad_idx, 0);
        got_addr.delete();
        cyc   = 0;
        dones = 0;
        while (ready === 1'b0 && cyc < 400) begin
            got_addr.push_back(dm_addr);
            if (done === 1'b1) dones++;
            if (poke && cyc == 1) valid = 1'b1;
            if (poke && cyc == 2) valid = 1'b0;
            cyc++;
            @(negedge clk);
        end
        chk({tag, " busy cycles"}, cyc, e_lat);
        chk({tag, " early done"}, dones, 0);
        chk({tag, " done"}, done, 1);
        chk({tag, " ok"}, ok, e_ok);
        chk({tag, " bad_idx"}, bad_idx, e_bad);
        addr_err = 0;
        if (got_addr.size() != exp_addr.size()) addr_err = 1;
        else for (int i = 0; i < exp_addr.size(); i++) if (got_addr[i] != exp_addr[i]) addr_err++;
        chk({tag, " addr seq errs"}, addr_err, 0);
    endtask

    task automatic after_done(input string tag);
        @(negedge clk);
        chk({tag, " ready held"}, ready, 1);
        chk({tag, " done one cycle"}, done, 0);
        chk({tag, " ok held"}, ok, e_ok);
        chk({tag, " bad held"}, bad_idx, e_bad);
    endtask

    task automatic load_hello();
        clear_mem();
        mem[0] = 8'h05; mem[1] = 8'h48; mem[2] = 8'h65;
        mem[3] = 8'h6C; mem[4] = 8'h6C; mem[5] = 8'h6F;
    endtask

    initial begin
        int dn;
        valid = 1'b0;
        rst_n = 1'b0;
        clear_mem();
        repeat (2) @(negedge clk);
        chk("reset ready", ready, 1);
        chk("reset ok", ok, 0);
        chk("reset bad_idx", bad_idx, 0);
        chk("reset done", done, 0);
        chk("reset dm_addr", dm_addr, 0);
        rst_n = 1'b1;

        load_hello();
        pulse_start();
        monitor("hello", 1'b0);
        after_done("hello");

        clear_mem();
        pulse_start();
        monitor("len0", 1'b0);
        after_done("len0");

        clear_mem();
        mem[0] = 8'h04; mem[1] = 8'h41; mem[2] = 8'h42; mem[3] = 8'h0A; mem[4] = 8'h43;
        pulse_start();
        monitor("abort3", 1'b0);
        after_done("abort3");

        clear_mem();
        mem[0] = 8'h04; mem[1] = 8'h20; mem[2] = 8'h7E; mem[3] = 8'h1F; mem[4] = 8'h7F;
        pulse_start();
        monitor("edge_1f", 1'b0);

        clear_mem();
        mem[0] = 8'h03; mem[1] = 8'h20; mem[2] = 8'h7E; mem[3] = 8'h7F;
        pulse_start();
        monitor("edge_7f", 1'b0);

        clear_mem();
        mem[0] = 8'h02; mem[1] = 8'h20; mem[2] = 8'h7E;
        pulse_start();
        monitor("edge_pass", 1'b1);
        after_done("edge_pass busy_poke");

        mem[0] = 8'hFF;
        for (int i = 1; i < 256; i++) mem[i] = 8'h61;
        pulse_start();
        monitor("len255", 1'b0);
        after_done("len255");

        load_hello();
        pulse_start();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst ready", ready, 1);
        chk("midrst ok", ok, 0);
        chk("midrst bad_idx", bad_idx, 0);
        chk("midrst dm_addr", dm_addr, 0);
        chk("midrst done", done, 0);
        dn = 0;
        repeat (2) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        chk("midrst no done", dn, 0);
        pulse_start();
        monitor("after_rst", 1'b0);
        after_done("after_rst");

        clear_mem();
        mem[0] = 8'h02; mem[1] = 8'h20; mem[2] = 8'h7E;
        @(negedge clk);
        valid = 1'b1;
        @(negedge clk);
        monitor("held1", 1'b0);
        @(negedge clk);
        chk("held restart ready", ready, 0);
        valid = 1'b0;
        monitor("held2", 1'b0);
        after_done("held2");

        for (int t = 0; t < 8; t++) begin
            int l;
            clear_mem();
            l = (t == 3) ? 0 : $urandom_range(1, 40);
            mem[0] = l[7:0];
            for (int i = 1; i <= l; i++) begin
                if ($urandom_range(0, 19) == 0) mem[i] = 8'($urandom_range(0, 255));
                else mem[i] = 8'($urandom_range(32, 126));
            end
            pulse_start();
            monitor($sformatf("rand%0d", t), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
